// File: rtl/replay_play_ctrl.sv
// replay_play_ctrl
//   Breaks a replay command into memory read bursts over a circular buffer.
//   One command runs at a time. NUM_ITEMS reads a fixed item count, REPEAT
//   makes N whole passes over the buffer, and CONTINUOUS loops until stopped.
//   Bursts never cross the buffer end and never exceed MAX_BURST beats.
//
// Ports
//   mem_clk, mem_rst_n      clock, async active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only when idle)
//   cmd_mode                0 NUM_ITEMS, 1 CONTINUOUS, 2 REPEAT, 3 reserved
//   cmd_num_items           item count for NUM_ITEMS
//   cmd_repeat              pass count for REPEAT
//   cfg_base_addr           buffer start byte address (word aligned)
//   cfg_buffer_size         buffer size in bytes
//   stop                    single-cycle stop request
//   rd_addr/rd_len          burst start byte address / beats minus one
//   rd_valid/rd_ready       burst request handshake
//   busy, done, err         status; done and err are one-cycle pulses
module replay_play_ctrl #(
  parameter int MEM_DATA_W = 64,
  parameter int MEM_ADDR_W = 30,
  parameter int ITEM_W     = 32,
  parameter int MAX_BURST  = 256,
  parameter int COUNT_W    = 32
) (
  input  logic                  mem_clk,
  input  logic                  mem_rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [63:0]           cmd_num_items,
  input  logic [COUNT_W-1:0]    cmd_repeat,
  input  logic [MEM_ADDR_W-1:0] cfg_base_addr,
  input  logic [MEM_ADDR_W:0]   cfg_buffer_size,
  input  logic                  stop,
  output logic [MEM_ADDR_W-1:0] rd_addr,
  output logic [7:0]            rd_len,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W   = MEM_DATA_W / 8;
  localparam int IPW = MEM_DATA_W / ITEM_W;
  localparam int WB  = $clog2(W);
  localparam int IB  = $clog2(IPW);

  localparam logic [1:0] M_NUM  = 2'd0;
  localparam logic [1:0] M_REP  = 2'd2;
  localparam logic [1:0] M_RSVD = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [63:0]           words_q, words_d;      // words left (NUM_ITEMS only)
  logic [COUNT_W-1:0]    pass_q, pass_d;        // passes left (REPEAT only)
  logic [MEM_ADDR_W-1:0] base_q, base_d;
  logic [63:0]           bufw_q, bufw_d;        // whole words in buffer
  logic [63:0]           off_q, off_d;          // word offset of next burst
  logic [8:0]            blen_q, blen_d;        // beats of current burst
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  stop_q, stop_d;

  logic        bad, stop_any, wrap, last;
  logic [63:0] to_end, burst, off_sum;

  always_ff @(posedge mem_clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      words_q <= '0;
      pass_q  <= '0;
      base_q  <= '0;
      bufw_q  <= '0;
      off_q   <= '0;
      blen_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      words_q <= words_d;
      pass_q  <= pass_d;
      base_q  <= base_d;
      bufw_q  <= bufw_d;
      off_q   <= off_d;
      blen_q  <= blen_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    words_d  = words_q;
    pass_d   = pass_q;
    base_d   = base_q;
    bufw_d   = bufw_q;
    off_d    = off_q;
    blen_d   = blen_q;
    addr_d   = addr_q;
    len_d    = len_q;
    stop_d   = stop_q | (stop && state_q != S_IDLE);
    err      = 1'b0;
    stop_any = stop_q | stop;
    // Command validity; these conditions can only hold on the first CALC of
    // a command, so re-evaluating them every CALC is harmless.
    bad      = (bufw_q == 64'd0) || (mode_q == M_RSVD) ||
               (mode_q == M_NUM && words_q == 64'd0) ||
               (mode_q == M_REP && pass_q == '0);
    to_end   = bufw_q - off_q;
    burst    = (to_end < 64'(MAX_BURST)) ? to_end : 64'(MAX_BURST);
    if (mode_q == M_NUM && words_q < burst) burst = words_q;
    off_sum  = off_q + 64'(blen_q);
    wrap     = (off_sum == bufw_q);
    last     = (mode_q == M_NUM && words_q == 64'(blen_q)) ||
               (mode_q == M_REP && wrap && pass_q == COUNT_W'(1));

    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (cmd_valid) begin
          mode_d  = cmd_mode;
          // ceil(items / IPW) without the overflow of adding IPW-1 first
          words_d = (cmd_num_items >> IB) +
                    64'(|(cmd_num_items & 64'(IPW - 1)));
          pass_d  = cmd_repeat;
          base_d  = cfg_base_addr;
          bufw_d  = 64'(cfg_buffer_size) >> WB;
          off_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (bad) begin
          err     = 1'b1;
          state_d = S_IDLE;
        end else if (stop_any) begin
          state_d = S_DONE;
        end else begin
          blen_d  = 9'(burst);
          len_d   = 8'(burst - 64'd1);
          addr_d  = base_q + MEM_ADDR_W'(off_q << WB);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // rd_valid stays up until accepted; a stop only acts afterwards
        if (rd_ready) begin
          off_d = wrap ? 64'd0 : off_sum;
          if (mode_q == M_NUM) words_d = words_q - 64'(blen_q);
          if (mode_q == M_REP && wrap) pass_d = pass_q - COUNT_W'(1);
          state_d = (last || stop_any) ? S_DONE : S_CALC;
        end
      end
      S_DONE: begin
        stop_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign rd_valid  = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign rd_addr   = addr_q;
  assign rd_len    = len_q;

endmodule

// File: tb/tb_replay_play_ctrl.sv
module tb_replay_play_ctrl;

  localparam int MDW = 64;
  localparam int MAW = 30;
  localparam int IW  = 32;
  localparam int MB  = 16;
  localparam int CW  = 32;
  localparam logic [MAW-1:0] BASE = 30'h1000;

  logic           mem_clk = 1'b0;
  logic           mem_rst_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_mode = '0;
  logic [63:0]    cmd_num_items = '0;
  logic [CW-1:0]  cmd_repeat = '0;
  logic [MAW-1:0] cfg_base_addr = BASE;
  logic [MAW:0]   cfg_buffer_size = '0;
  logic           stop = 1'b0;
  logic [MAW-1:0] rd_addr;
  logic [7:0]     rd_len;
  logic           rd_valid;
  logic           rd_ready = 1'b0;
  logic           busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  replay_play_ctrl #(.MEM_DATA_W(MDW), .MEM_ADDR_W(MAW), .ITEM_W(IW),
                     .MAX_BURST(MB), .COUNT_W(CW)) dut (
    .mem_clk(mem_clk), .mem_rst_n(mem_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_num_items(cmd_num_items), .cmd_repeat(cmd_repeat),
    .cfg_base_addr(cfg_base_addr), .cfg_buffer_size(cfg_buffer_size),
    .stop(stop), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 mem_clk = ~mem_clk;

  // Stimulus helpers (no comparisons inside)
  task automatic tick();
    @(posedge mem_clk); #1;
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic [63:0] n,
                          input logic [CW-1:0] r, input logic [MAW:0] sz);
    cmd_mode = m; cmd_num_items = n; cmd_repeat = r; cfg_buffer_size = sz;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_burst(output bit ok, output logic [MAW-1:0] a,
                           output logic [7:0] l);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
    a = rd_addr; l = rd_len;
    if (ok) begin
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if ({rd_valid, busy, done, err} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags got=%b exp=0000", {rd_valid, busy, done, err}); end
    n_checks++; if (rd_addr !== '0 || rd_len !== 8'd0) begin n_fail++;
      $display("FAIL reset_addr_len got=%h/%h exp=0/0", rd_addr, rd_len); end
    #10 mem_rst_n = 1'b1;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_num_items();
    bit ok; logic [MAW-1:0] a; logic [7:0] l;
    send_cmd(2'd0, 64'd40, '0, 31'h100);
    n_checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++;
      $display("FAIL num_busy got=%b%b exp=10", busy, cmd_ready); end
    get_burst(ok, a, l);
    n_checks++; if (!ok || a !== 30'h1000 || l !== 8'd15) begin n_fail++;
      $display("FAIL num_b0 got=%0b,%h,%0d exp=1,1000,15", ok, a, l); end
    n_checks++; if (done !== 1'b0) begin n_fail++;
      $display("FAIL num_early_done got=%b exp=0", done); end
    get_burst(ok, a, l);
    n_checks++; if (!ok || a !== 30'h1080 || l !== 8'd3) begin n_fail++;
      $display("FAIL num_b1 got=%0b,%h,%0d exp=1,1080,3", ok, a, l); end
    n_checks++; if (done !== 1'b1) begin n_fail++;
      $display("FAIL num_done got=%b exp=1", done); end
    tick();
    n_checks++; if ({done, busy, cmd_ready} !== 3'b001) begin n_fail++;
      $display("FAIL num_idle got=%b exp=001", {done, busy, cmd_ready}); end
  endtask

  task automatic test_wrap();
    bit ok; logic [MAW-1:0] a; logic [7:0] l;
    send_cmd(2'd0, 64'd23, '0, 31'h40);
    get_burst(ok, a, l);
    n_checks++; if (!ok || a !== 30'h1000 || l !== 8'd7) begin n_fail++;
      $display("FAIL wrap_b0 got=%0b,%h,%0d exp=1,1000,7", ok, a, l); end
    get_burst(ok, a, l);
    n_checks++; if (!ok || a !== 30'h1000 || l !== 8'd3) begin n_fail++;
      $display("FAIL wrap_b1 got=%0b,%h,%0d exp=1,1000,3", ok, a, l); end
    n_checks++; if (done !== 1'b1) begin n_fail++;
      $display("FAIL wrap_done got=%b exp=1", done); end
    tick();
  endtask

  task automatic test_repeat();
    bit ok; logic [MAW-1:0] a; logic [7:0] l;
    send_cmd(2'd2, 64'd0, 32'd3, 31'h40);
    for (int p = 0; p < 3; p++) begin
      get_burst(ok, a, l);
      n_checks++; if (!ok || a !== 30'h1000 || l !== 8'd7) begin n_fail++;
        $display("FAIL rep_b%0d got=%0b,%h,%0d exp=1,1000,7", p, ok, a, l); end
      n_checks++; if (done !== (p == 2)) begin n_fail++;
        $display("FAIL rep_done%0d got=%b exp=%b", p, done, p == 2); end
    end
    tick();
    n_checks++; if (rd_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL rep_idle got=%b%b exp=01", rd_valid, cmd_ready); end
  endtask

  task automatic test_stop();
    bit ok; logic [MAW-1:0] a; logic [7:0] l; int seen;
    send_cmd(2'd1, 64'd0, '0, 31'h100);
    tick();
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++;
      $display("FAIL stop_valid got=%b exp=1", rd_valid); end
    stop = 1'b1; tick(); stop = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid !== 1'b1 || rd_addr !== 30'h1000 || rd_len !== 8'd15) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++;
      $display("FAIL stop_stable got=%0d unstable cycles exp=0", seen); end
    get_burst(ok, a, l);
    n_checks++; if (!ok || done !== 1'b1 || rd_valid !== 1'b0) begin n_fail++;
      $display("FAIL stop_done got=%0b,%b,%b exp=1,1,0", ok, done, rd_valid); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (rd_valid !== 1'b0) seen++; end
    n_checks++; if (seen !== 0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL stop_quiet got=%0d,%b exp=0,1", seen, cmd_ready); end
  endtask

  task automatic test_err();
    logic [1:0] m [3]; logic [CW-1:0] r [3]; logic [MAW:0] s [3];
    m = '{2'd0, 2'd2, 2'd3}; r = '{32'd0, 32'd0, 32'd1};
    s = '{31'h4, 31'h40, 31'h40};
    for (int k = 0; k < 3; k++) begin
      send_cmd(m[k], 64'd10, r[k], s[k]);
      n_checks++; if (err !== 1'b1 || rd_valid !== 1'b0) begin n_fail++;
        $display("FAIL err%0d_pulse got=%b,%b exp=1,0", k, err, rd_valid); end
      tick();
      n_checks++; if ({err, rd_valid, cmd_ready, done} !== 4'b0010) begin n_fail++;
        $display("FAIL err%0d_after got=%b exp=0010", k, {err, rd_valid, cmd_ready, done}); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [MAW-1:0] a; logic [7:0] l;
    send_cmd(2'd0, 64'd1, '0, 31'h100);
    get_burst(ok, a, l);
    n_checks++; if (!ok || a !== 30'h1000 || l !== 8'd0 || done !== 1'b1) begin n_fail++;
      $display("FAIL b2b_0 got=%0b,%h,%0d,%b exp=1,1000,0,1", ok, a, l, done); end
    tick();
    send_cmd(2'd0, 64'd3, '0, 31'h100);
    get_burst(ok, a, l);
    n_checks++; if (!ok || a !== 30'h1000 || l !== 8'd1 || done !== 1'b1) begin n_fail++;
      $display("FAIL b2b_1 got=%0b,%h,%0d,%b exp=1,1000,1,1", ok, a, l, done); end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    send_cmd(2'd1, 64'd0, '0, 31'h100);
    tick();
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_valid got=%b exp=1", rd_valid); end
    #1 mem_rst_n = 1'b0;
    #1;
    n_checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rstmid_async got=%b%b exp=00", rd_valid, busy); end
    tick();
    mem_rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (rd_valid !== 1'b0) seen++; end
    n_checks++; if (seen !== 0 || cmd_ready !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_quiet got=%0d,%b exp=0,1", seen, cmd_ready); end
  endtask

  initial begin
    test_reset();
    test_num_items();
    test_wrap();
    test_repeat();
    test_stop();
    test_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/replay_play_ctrl.md
REPLAY_PLAY_CTRL -- requirements
Module: replay_play_ctrl

Interface
REQ-001 SHALL have parameter MEM_DATA_W, default 64: memory word width in bits; power of 2, 32..512.
REQ-002 SHALL have parameter MEM_ADDR_W, default 30: byte address width, 16..40.
REQ-003 SHALL have parameter ITEM_W, default 32: item width in bits; 8, 16 or 32.
REQ-004 SHALL have parameter MAX_BURST, default 256: maximum words per read burst; power of 2, 1..256.
REQ-005 SHALL have parameter COUNT_W, default 32: repeat-count width.
REQ-006 SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-007 SHALL have ports (name, direction, width, meaning):
- mem_clk  in  1  sole clock
- mem_rst_n  in  1  async active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_mode  in  2  0=NUM_ITEMS, 1=CONTINUOUS, 2=REPEAT, 3=reserved
- cmd_num_items  in  64  item count (NUM_ITEMS mode)
- cmd_repeat  in  COUNT_W  buffer passes (REPEAT mode)
- cfg_base_addr  in  MEM_ADDR_W  buffer start byte address, word aligned
- cfg_buffer_size  in  MEM_ADDR_W+1  buffer size in bytes
- stop  in  1  single-cycle stop request
- rd_addr  out  MEM_ADDR_W  burst start byte address
- rd_len  out  8  burst beats minus one
- rd_valid / rd_ready  out / in  1 / 1  burst request handshake
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse on rejected command

Function
REQ-008 SHALL use W = MEM_DATA_W/8 bytes per word and IPW = MEM_DATA_W/ITEM_W items per word.
REQ-009 SHALL implement states IDLE, CALC, ISSUE, DONE; cmd_ready=1 only in IDLE; handshake in IDLE latches all cmd_* and cfg_* inputs and enters CALC.
REQ-010 SHALL, on acceptance, pulse err and return to IDLE without issuing bursts if cfg_buffer_size < W, cmd_mode=3, NUM_ITEMS with cmd_num_items=0, or REPEAT with cmd_repeat=0.
REQ-011 SHALL, in NUM_ITEMS mode, round item count up to words: ceil(cmd_num_items/IPW).
REQ-012 SHALL, in REPEAT mode, read floor(cfg_buffer_size/W) words cmd_repeat times; in CONTINUOUS mode, read unbounded.
REQ-013 SHALL start at cfg_base_addr; when the next address reaches base+floor(size/W)*W, wrap to base.
REQ-014 SHALL compute in CALC (1 cycle) burst length = min(MAX_BURST, words remaining in command, words to buffer end); bursts never cross buffer end.
REQ-015 SHALL in ISSUE assert rd_valid with rd_addr/rd_len stable until rd_valid&&rd_ready; then advance address and counters and return to CALC, or enter DONE when no words remain.
REQ-016 SHALL register stop in any non-IDLE state; pending stop takes effect at next CALC or after the current ISSUE handshake, never withdrawing an asserted rd_valid; then enter DONE.
REQ-017 SHALL ignore stop in IDLE.
REQ-018 SHALL in DONE pulse done for exactly one cycle and return to IDLE; busy=1 in CALC, ISSUE, DONE.
REQ-019 SHALL use 64-bit word counters and COUNT_W-bit pass counter without overflow for any legal input.

Reset
REQ-020 SHALL, on mem_rst_n low, immediately force state IDLE, clear pending stop, and drive rd_valid=0, busy=0, done=0, err=0, rd_addr=0, rd_len=0; cmd_ready=1 on the first edge after release.
REQ-021 SHALL discard any in-flight command on reset; no bursts issue after release until a new command.

Verification (MEM_DATA_W=64, ITEM_W=32, MAX_BURST=16, base 0x1000)
REQ-022 SHALL verify: size 0x100, NUM_ITEMS 40 -> bursts (0x1000,15), (0x1080,3), then done.
REQ-023 SHALL verify: size 0x40, NUM_ITEMS 23 -> 12 words: (0x1000,7), (0x1000,3) after wrap, done.
REQ-024 SHALL verify: size 0x40, REPEAT 3 -> three bursts (0x1000,7), done after third handshake.
REQ-025 SHALL verify: CONTINUOUS, stop pulsed while rd_valid=1 and rd_ready=0 -> rd_addr/rd_len stable; after acceptance no further rd_valid; done pulses.
REQ-026 SHALL verify: size 0x4 or REPEAT 0 -> err pulse 1 cycle, rd_valid never asserted, cmd_ready returns next cycle.
REQ-027 SHALL verify: mem_rst_n low mid-ISSUE -> rd_valid and busy fall asynchronously; no bursts issue after release.
